// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fifo_wr_arbiter_if
// Brief  : Requester bundle plus FIFO write port shared by fifo_wr_arbiter
//          and its environment.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ack;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  wr_full;
  logic                  wr_en;
  logic [DSIZE-1:0]      wr_data;

  // Arbiter side: consumes requests and full flag, drives the FIFO write port
  modport master (
    input  req_valid, req_data, req_last, wr_full,
    output req_ack, grant, busy, wr_en, wr_data
  );

  // Environment side: requesters plus the FIFO itself
  modport slave (
    output req_valid, req_data, req_last, wr_full,
    input  req_ack, grant, busy, wr_en, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fifo_wr_arbiter
// Brief  : Round-robin arbiter sharing one FIFO write port among NREQ
//          requesters, bounded bursts, wr_full back-pressure.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  fifo_wr_arbiter_if.master   bus
);

  localparam int OW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_owner_q, last_owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            xfer;
  logic            rel;
  logic            found;
  logic [OW-1:0]   pick;
  logic [OW-1:0]   cand;

  // Increment an owner index with an explicit NREQ-1 -> 0 wrap
  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] x);
    return (x == OW'(NREQ - 1)) ? '0 : x + OW'(1);
  endfunction

  // Round-robin search starting just after the previous owner
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = last_owner_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_inc(cand);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // A beat moves only when the owner has data and the FIFO has room
  always_comb begin
    xfer = (state_q == S_BURST) && bus.req_valid[owner_q] && !bus.wr_full;
    rel  = (state_q == S_BURST) &&
           ((xfer && (bus.req_last[owner_q] ||
                      (beat_cnt_q == BW'(MAX_BURST - 1)))) ||
            !bus.req_valid[owner_q]);
  end

  // Next-state logic: arbitrate in IDLE, count beats and release in BURST
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d    = pick;
          grant_d    = NREQ'(1) << pick;
          beat_cnt_d = '0;
          state_d    = S_BURST;
        end
      end
      S_BURST: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
        if (rel) begin
          state_d      = S_IDLE;
          grant_d      = '0;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; last_owner resets to NREQ-1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
      grant_q      <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Outputs derive from registered state, so reset silences wr_en at once
  assign bus.wr_en   = xfer;
  assign bus.req_ack = xfer ? grant_q : '0;
  assign bus.grant   = grant_q;
  assign bus.busy    = (state_q == S_BURST);
  assign bus.wr_data = (state_q == S_BURST) ?
                       bus.req_data[int'(owner_q)*DSIZE +: DSIZE] : '0;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.grant));
  a_wr_en_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    bus.wr_en |-> !bus.wr_full);
  a_ack_single: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(bus.req_ack) <= 1);
  a_ack_matches: assert property (@(posedge clk) disable iff (!rst_n)
    bus.req_ack == (bus.wr_en ? bus.grant : '0));

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_fifo_wr_arbiter
// Brief  : Directed table vectors plus hand sequences for fifo_wr_arbiter.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] v;
    logic [3:0] last;
    logic       full;
    logic [3:0] g;
    logic       en;
    logic [3:0] ack;
    logic       busy;
    logic [7:0] d;
  } vec_t;

  vec_t vt[24];

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.wr_full   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt[4];
    logic [7:0] expd[$];
    logic [3:0] expg[$];
    int   writes, stall_left, stalls, pulses, r;
    logic chk_next, seen;

    // v, last, full | grant, wr_en, ack, busy, wr_data
    vt[0]  = '{4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    vt[1]  = '{4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0};
    vt[2]  = '{4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0};
    vt[3]  = '{4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0};
    vt[4]  = '{4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0};
    vt[5]  = '{4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    vt[6]  = '{4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2};
    vt[7]  = '{4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2};
    vt[8]  = '{4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2};
    vt[9]  = '{4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2};
    vt[10] = '{4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    vt[11] = '{4'b0101, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0};
    vt[12] = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    vt[13] = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'hC2};
    vt[14] = '{4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2};
    vt[15] = '{4'b0001, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'hC2};
    vt[16] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    vt[17] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0};
    vt[18] = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'hA0};
    vt[19] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    vt[20] = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    vt[21] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'hB1};
    vt[22] = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'hB1};
    vt[23] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};

    // Reset state
    do_reset();
    #1;
    check("reset_grant", 32'(bus.grant), 32'h0);
    check("reset_busy",  32'(bus.busy),  32'h0);
    check("reset_wr_en", 32'(bus.wr_en), 32'h0);
    check("reset_ack",   32'(bus.req_ack), 32'h0);
    check("reset_data",  32'(bus.wr_data), 32'h0);

    // Table vectors with fixed per-requester data
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      bus.req_valid = vt[k].v;
      bus.req_last  = vt[k].last;
      bus.wr_full   = vt[k].full;
      bus.req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      #1;
      check($sformatf("vec%0d_grant", k), 32'(bus.grant),   32'(vt[k].g));
      check($sformatf("vec%0d_wr_en", k), 32'(bus.wr_en),   32'(vt[k].en));
      check($sformatf("vec%0d_ack", k),   32'(bus.req_ack), 32'(vt[k].ack));
      check($sformatf("vec%0d_busy", k),  32'(bus.busy),    32'(vt[k].busy));
      check($sformatf("vec%0d_data", k),  32'(bus.wr_data), 32'(vt[k].d));
    end

    // All requesters valid, 5-cycle stall after beat 2 of requester 1
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < MAX_BURST; b++) begin
        r = g % 4;
        expd.push_back(8'((r << 4) | ((g / 4) * MAX_BURST + b)));
        expg.push_back(4'(1 << r));
      end
    end
    writes = 0; stall_left = 0; stalls = 0;
    for (int cyc = 0; cyc < 150 && writes < 20; cyc++) begin
      @(negedge clk);
      bus.req_valid = 4'hF;
      bus.req_last  = '0;
      bus.wr_full   = (stall_left > 0);
      for (int i = 0; i < 4; i++) bus.req_data[i*DSIZE +: DSIZE] = 8'((i << 4) | cnt[i]);
      #1;
      if (bus.wr_full) begin
        check("stall_wr_en", 32'(bus.wr_en),   32'h0);
        check("stall_ack",   32'(bus.req_ack), 32'h0);
        check("stall_grant", 32'(bus.grant),   32'h2);
        stall_left--;
        stalls++;
      end
      if (bus.wr_en) begin
        check($sformatf("rr_data%0d", writes),  32'(bus.wr_data), 32'(expd[writes]));
        check($sformatf("rr_grant%0d", writes), 32'(bus.grant),   32'(expg[writes]));
        check($sformatf("rr_ack%0d", writes),   32'(bus.req_ack), 32'(expg[writes]));
        for (int i = 0; i < 4; i++) if (bus.req_ack[i]) cnt[i]++;
        writes++;
        if (writes == 6) stall_left = 5;
      end
    end
    check("rr_writes", 32'(writes), 32'd20);
    check("stall_cycles", 32'(stalls), 32'd5);

    // Requester 1 alone: 3 beats ending with req_last
    do_reset();
    pulses = 0; chk_next = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      bus.req_valid = (pulses < 3) ? 4'b0010 : 4'b0000;
      bus.req_last  = (pulses == 2) ? 4'b0010 : 4'b0000;
      bus.req_data  = {8'h00, 8'h00, 8'(8'h10 + pulses), 8'h00};
      bus.wr_full   = 1'b0;
      #1;
      if (chk_next) begin
        check("last_rel_grant", 32'(bus.grant), 32'h0);
        check("last_rel_busy",  32'(bus.busy),  32'h0);
        chk_next = 1'b0;
      end
      if (bus.wr_en) begin
        check($sformatf("last_data%0d", pulses), 32'(bus.wr_data), 32'(8'h10 + pulses));
        pulses++;
        if (pulses == 3) chk_next = 1'b1;
      end
    end
    check("last_pulses", 32'(pulses), 32'd3);

    // Asynchronous reset in the middle of requester 1's burst
    do_reset();
    seen = 1'b0;
    for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
      @(negedge clk);
      bus.req_valid = 4'b0011;
      bus.req_data  = {8'h00, 8'h00, 8'hB1, 8'hA0};
      #1;
      if (bus.wr_en && bus.grant == 4'b0010) seen = 1'b1;
    end
    check("arst_reached_burst", 32'(seen), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_wr_en", 32'(bus.wr_en), 32'h0);
    check("arst_grant", 32'(bus.grant), 32'h0);
    check("arst_busy",  32'(bus.busy),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_idle_grant", 32'(bus.grant), 32'h0);
    @(negedge clk);
    #1;
    check("arst_first_grant", 32'(bus.grant), 32'h1);
    check("arst_first_data",  32'(bus.wr_data), 32'hA0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
